// File: rtl/perf_uart_tx.sv
// Streams the eight performance-counter words to a host PC as one 8N1 UART frame per start edge.
// Optional checksum byte: define PERF_UART_TX_CHECKSUM_EN.
module perf_uart_tx #(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         NUM_WORDS    = 8,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [2:0]  word_sel,
    input  logic [31:0] word_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] PRE_TICK  = TW'(CLKS_PER_BIT - 2);
    localparam logic [2:0]    LAST_WORD = 3'(NUM_WORDS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SYNC = 2'd1;
    localparam logic [1:0] SEND = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;

    logic [1:0]    state;
    logic          startQ;
    logic          startEdge;
    logic [TW-1:0] bitTimer;
    logic [3:0]    bitCnt;
    logic [9:0]    shiftReg;
    logic [31:0]   wordReg;
    logic [1:0]    byteIdx;
    logic [2:0]    wordIdx;
    logic          isSync;
`ifdef PERF_UART_TX_CHECKSUM_EN
    logic [7:0]    csum;
    logic          csumPhase;
`endif

    function automatic logic [9:0] frameByte(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    assign startEdge = start & ~startQ;
    assign tx   = (state == SEND) ? shiftReg[0] : 1'b1;
    assign busy = (state == SYNC) || (state == SEND);
    assign done = (state == FIN);

    // The word load happens on the edge that ends the previous stop bit, so the
    // next start bit follows with no idle cycle; word_sel is moved one cycle
    // earlier so word_data has settled by then.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            startQ    <= 1'b0;
            bitTimer  <= '0;
            bitCnt    <= '0;
            shiftReg  <= '1;
            wordReg   <= '0;
            byteIdx   <= '0;
            wordIdx   <= '0;
            word_sel  <= '0;
            isSync    <= 1'b0;
`ifdef PERF_UART_TX_CHECKSUM_EN
            csum      <= '0;
            csumPhase <= 1'b0;
`endif
        end else begin
            startQ <= start;
            case (state)
                IDLE: begin
                    if (startEdge) begin
                        state <= SYNC;
`ifdef PERF_UART_TX_CHECKSUM_EN
                        csum  <= '0;
`endif
                    end
                end
                SYNC: begin
                    shiftReg  <= frameByte(SYNC_BYTE);
                    isSync    <= 1'b1;
                    bitTimer  <= '0;
                    bitCnt    <= '0;
                    byteIdx   <= '0;
                    wordIdx   <= '0;
`ifdef PERF_UART_TX_CHECKSUM_EN
                    csumPhase <= 1'b0;
`endif
                    state     <= SEND;
                end
                SEND: begin
                    if (bitTimer == LAST_TICK) begin
                        bitTimer <= '0;
                        if (bitCnt == 4'd9) begin
                            bitCnt <= '0;
                            if (isSync) begin
                                isSync   <= 1'b0;
                                wordIdx  <= '0;
                                byteIdx  <= '0;
                                wordReg  <= word_data;
                                shiftReg <= frameByte(word_data[7:0]);
`ifdef PERF_UART_TX_CHECKSUM_EN
                                csum     <= csum ^ word_data[7:0];
`endif
                            end else if (byteIdx != 2'd3) begin
                                byteIdx  <= byteIdx + 2'd1;
                                wordReg  <= {8'h00, wordReg[31:8]};
                                shiftReg <= frameByte(wordReg[15:8]);
`ifdef PERF_UART_TX_CHECKSUM_EN
                                csum     <= csum ^ wordReg[15:8];
`endif
                            end else if (wordIdx != LAST_WORD) begin
                                wordIdx  <= wordIdx + 3'd1;
                                byteIdx  <= '0;
                                wordReg  <= word_data;
                                shiftReg <= frameByte(word_data[7:0]);
`ifdef PERF_UART_TX_CHECKSUM_EN
                                csum     <= csum ^ word_data[7:0];
                            end else if (!csumPhase) begin
                                csumPhase <= 1'b1;
                                shiftReg  <= frameByte(csum);
`endif
                            end else begin
                                state <= FIN;
                            end
                        end else begin
                            bitCnt   <= bitCnt + 4'd1;
                            shiftReg <= {1'b1, shiftReg[9:1]};
                        end
                    end else begin
                        bitTimer <= bitTimer + 1'b1;
                        if (bitTimer == PRE_TICK && bitCnt == 4'd9) begin
                            if (isSync)
                                word_sel <= '0;
                            else if (byteIdx == 2'd3 && wordIdx != LAST_WORD)
                                word_sel <= wordIdx + 3'd1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    word_sel <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_perf_uart_tx.sv
// Directed bench for perf_uart_tx: a UART line decoder pops expected bytes from a scoreboard queue.
module tb_perf_uart_tx;
    localparam int CPB = 4;
    localparam int NW  = 8;
`ifdef PERF_UART_TX_CHECKSUM_EN
    localparam int FRAME_BYTES = 2 + 4 * NW;
`else
    localparam int FRAME_BYTES = 1 + 4 * NW;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  word_sel;
    logic [31:0] word_data;
    logic        tx;
    logic        busy;
    logic        done;

    logic [31:0] wordVals [NW];
    logic [7:0]  expQ [$];
    int checks = 0;
    int errors = 0;
    int doneCnt = 0;
    int busyCycles = 0;

    perf_uart_tx #(.CLKS_PER_BIT(CPB), .NUM_WORDS(NW), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .reset(reset), .start(start), .word_sel(word_sel),
        .word_data(word_data), .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always_comb word_data = wordVals[word_sel];

    always @(posedge clk) begin
        if (done) doneCnt <= doneCnt + 1;
        if (busy) busyCycles <= busyCycles + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pushFrame();
        logic [7:0] x = 8'h00;
        logic [7:0] b;
        expQ.push_back(8'hA5);
        for (int w = 0; w < NW; w++)
            for (int k = 0; k < 4; k++) begin
                b = wordVals[w][8*k +: 8];
                expQ.push_back(b);
                x = x ^ b;
            end
`ifdef PERF_UART_TX_CHECKSUM_EN
        expQ.push_back(x);
`endif
    endtask

    // Waits up to maxWait cycles for a start bit, then samples every cycle of the 10 bits.
    task automatic recvByte(input int maxWait, output logic [7:0] data, output bit ok);
        logic [9:0] bits;
        bit found = 0;
        ok = 1;
        data = 8'h00;
        for (int i = 0; i < maxWait; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            ok = 0;
            return;
        end
        bits = '0;
        for (int b = 0; b < 10; b++)
            for (int k = 0; k < CPB; k++) begin
                if (b == 0 && k == 0) continue;
                @(negedge clk);
                if (k == 0) bits[b] = tx;
                else if (tx !== bits[b]) ok = 0;
            end
        if (bits[9] !== 1'b1) ok = 0;
        data = bits[8:1];
    endtask

    task automatic runFrame(input bit holdStart, input int injAt, input int abortAt);
        int d0, b0;
        logic [7:0] data;
        logic [7:0] exp;
        bit ok;
        pushFrame();
        d0 = doneCnt;
        b0 = busyCycles;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        if (!holdStart) start = 1'b0;
        check("busy_rise", busy, 1);
        check("tx_high_before_start_bit", tx, 1);
        for (int i = 0; i < FRAME_BYTES; i++) begin
            if (i == abortAt) begin
                repeat (10) @(negedge clk);
                reset = 1'b0;
                #1;
                check("abort_tx", tx, 1);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                expQ.delete();
                repeat (3) @(negedge clk);
                reset = 1'b1;
                repeat (2) @(negedge clk);
                check("abort_no_done", doneCnt - d0, 0);
                check("abort_word_sel", word_sel, 0);
                return;
            end
            if (i == injAt) start = 1'b1;
            recvByte(1, data, ok);
            if (i == injAt) start = 1'b0;
            exp = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
            check($sformatf("byte%0d", i), data, exp);
            check($sformatf("framing%0d", i), ok, 1);
        end
        @(negedge clk);
        check("done_pulse", done, 1);
        check("busy_fall", busy, 0);
        @(negedge clk);
        check("done_single", done, 0);
        check("done_count", doneCnt - d0, 1);
        check("busy_cycles", busyCycles - b0, 1 + FRAME_BYTES * 10 * CPB);
    endtask

    task automatic idleCheck(input string tag, input int cycles);
        int bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        check(tag, bad, 0);
    endtask

    initial begin
        int badTx, badBusy, badDone, badSel;
        reset = 1'b0;
        start = 1'b0;
        for (int w = 0; w < NW; w++) wordVals[w] = 32'h11223344 + w;
        repeat (2) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_word_sel", word_sel, 0);
        reset = 1'b1;

        badTx = 0; badBusy = 0; badDone = 0; badSel = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) badTx++;
            if (busy !== 1'b0) badBusy++;
            if (done !== 1'b0) badDone++;
            if (word_sel !== 3'd0) badSel++;
        end
        check("idle_tx", badTx, 0);
        check("idle_busy", badBusy, 0);
        check("idle_done", badDone, 0);
        check("idle_word_sel", badSel, 0);

        runFrame(1'b0, -1, -1);

        runFrame(1'b1, -1, -1);
        idleCheck("held_start_no_refire", 3000 - FRAME_BYTES * 10 * CPB);
        start = 1'b0;
        @(negedge clk);
        runFrame(1'b0, -1, -1);

        runFrame(1'b0, 10, -1);
        idleCheck("midframe_start_ignored", 100);

        runFrame(1'b0, -1, 14);
        check("abort_queue_empty", expQ.size(), 0);
        idleCheck("after_abort_idle", 20);
        runFrame(1'b0, -1, -1);

`ifdef PERF_UART_TX_CHECKSUM_EN
        for (int w = 0; w < NW; w++) wordVals[w] = 32'h01020304;
        runFrame(1'b0, -1, -1);
        wordVals[0] = 32'h000000FF;
        for (int w = 1; w < NW; w++) wordVals[w] = 32'h0;
        runFrame(1'b0, -1, -1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
